// File: rtl/modport_fifo_pkg.sv
// Shared widths and types for the modport_fifo datapath.
// Optional o_count port is enabled by MODPORT_FIFO_COUNT_EN.
package modport_fifo_pkg;
   localparam int DATA_W = 128;
   localparam int DEPTH  = 16;
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [PTR_W-1:0]  ptr_t;
   typedef logic [CNT_W-1:0]  cnt_t;
endpackage

// File: rtl/modport_fifo_mem.sv
// 1-write/1-read storage array with a registered read port.
// Storage is never cleared; only the read register resets.
module modport_fifo_mem
   import modport_fifo_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  we,
   input  ptr_t  waddr,
   input  data_t wdata,
   input  logic  re,
   input  ptr_t  raddr,
   output data_t rdata
);

   data_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/modport_fifo.sv
// Single-clock FIFO: pointers, occupancy count, flags, acceptance.
// Define MODPORT_FIFO_COUNT_EN to expose the count as o_count.
module modport_fifo
   import modport_fifo_pkg::*;
#(
   parameter int ALM_FULL_TH  = 2,
   parameter int ALM_EMPTY_TH = 2
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              i_wren,
   input  logic              i_rden,
   input  logic [DATA_W-1:0] i_wrdata,
   output logic              o_full,
   output logic              o_empty,
   output logic              o_alm_full,
   output logic              o_alm_empty,
`ifdef MODPORT_FIFO_COUNT_EN
   output logic [PTR_W:0]    o_count,
`endif
   output logic [DATA_W-1:0] o_rddata
);

   localparam cnt_t FULL_CNT = CNT_W'(DEPTH);
   localparam cnt_t AF_CNT   = CNT_W'(DEPTH - ALM_FULL_TH);
   localparam cnt_t AE_CNT   = CNT_W'(ALM_EMPTY_TH);

   ptr_t  wr_ptr;
   ptr_t  rd_ptr;
   cnt_t  count;
   logic  wr_acc;
   logic  rd_acc;

   // Requests in a reset cycle must not touch storage or pointers.
   assign wr_acc = i_wren & ~o_full  & ~rstn;
   assign rd_acc = i_rden & ~o_empty & ~rstn;

   always_ff @(posedge clk) begin
      if (rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         unique case ({wr_acc, rd_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign o_full      = (count == FULL_CNT);
   assign o_empty     = (count == '0);
   assign o_alm_full  = (count >= AF_CNT);
   assign o_alm_empty = (count <= AE_CNT);

`ifdef MODPORT_FIFO_COUNT_EN
   assign o_count = count;
`endif

   modport_fifo_mem u_mem (
      .clk   (clk),
      .rst   (rstn),
      .we    (wr_acc),
      .waddr (wr_ptr),
      .wdata (i_wrdata),
      .re    (rd_acc),
      .raddr (rd_ptr),
      .rdata (o_rddata)
   );

endmodule

// File: tb/tb_modport_fifo.sv
// Directed self-checking bench for modport_fifo.
// Expected values are hand-derived from the FIFO's occupancy rules.
module tb_modport_fifo;
   import modport_fifo_pkg::*;

   logic        clk = 1'b0;
   logic        rstn;
   logic        i_wren;
   logic        i_rden;
   data_t       i_wrdata;
   logic        o_full;
   logic        o_empty;
   logic        o_alm_full;
   logic        o_alm_empty;
   data_t       o_rddata;
`ifdef MODPORT_FIFO_COUNT_EN
   logic [PTR_W:0] o_count;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   modport_fifo dut (
      .clk         (clk),
      .rstn        (rstn),
      .i_wren      (i_wren),
      .i_rden      (i_rden),
      .i_wrdata    (i_wrdata),
      .o_full      (o_full),
      .o_empty     (o_empty),
      .o_alm_full  (o_alm_full),
      .o_alm_empty (o_alm_empty),
`ifdef MODPORT_FIFO_COUNT_EN
      .o_count     (o_count),
`endif
      .o_rddata    (o_rddata)
   );

   task automatic chk(input string tag, input data_t obs, input data_t exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Flags implied by an occupancy of n with thresholds 2/2, depth 16.
   task automatic chk_flags(input string tag, input int n);
      chk({tag, ".empty"},  data_t'(o_empty),     data_t'(n == 0));
      chk({tag, ".aempty"}, data_t'(o_alm_empty), data_t'(n <= 2));
      chk({tag, ".afull"},  data_t'(o_alm_full),  data_t'(n >= 14));
      chk({tag, ".full"},   data_t'(o_full),      data_t'(n == 16));
`ifdef MODPORT_FIFO_COUNT_EN
      chk({tag, ".count"},  data_t'(o_count),     data_t'(n));
`endif
   endtask

   // One clock with the given requests; outputs are sampled 1ns after.
   task automatic cyc(input logic w, input logic r, input data_t d);
      i_wren   = w;
      i_rden   = r;
      i_wrdata = d;
      @(posedge clk);
      #1;
      i_wren   = 1'b0;
      i_rden   = 1'b0;
   endtask

   initial begin
      rstn     = 1'b1;
      i_wren   = 1'b0;
      i_rden   = 1'b0;
      i_wrdata = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rstn = 1'b0;

      // Reset state
      chk_flags("reset", 0);
      chk("reset.rddata", o_rddata, '0);
      cyc(1'b0, 1'b0, '0);
      chk_flags("idle", 0);

      // Fill with 1..16, then a dropped 17th write
      for (int k = 1; k <= 16; k++) begin
         cyc(1'b1, 1'b0, data_t'(k));
         chk_flags($sformatf("fill%0d", k), k);
      end
      cyc(1'b1, 1'b0, data_t'(128'hFF));
      chk_flags("overfill", 16);

      // Drain in order
      for (int k = 1; k <= 16; k++) begin
         cyc(1'b0, 1'b1, '0);
         chk($sformatf("drain%0d", k), o_rddata, data_t'(k));
         chk_flags($sformatf("drain%0d", k), 16 - k);
      end
      cyc(1'b0, 1'b1, '0);
      chk("underflow.rddata", o_rddata, data_t'(16));
      chk_flags("underflow", 0);

      // Steady state at count 5 across pointer wrap
      for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, data_t'(32'h100 + k));
      chk_flags("pre_stream", 5);
      for (int k = 0; k < 20; k++) begin
         cyc(1'b1, 1'b1, data_t'(32'h105 + k));
         chk($sformatf("stream%0d", k), o_rddata, data_t'(32'h100 + k));
      end
      chk_flags("post_stream", 5);
      for (int k = 0; k < 5; k++) begin
         cyc(1'b0, 1'b1, '0);
         chk($sformatf("tail%0d", k), o_rddata, data_t'(32'h114 + k));
      end
      chk_flags("tail_done", 0);

      // Full with simultaneous read and write
      for (int k = 0; k < 16; k++) cyc(1'b1, 1'b0, data_t'(32'h200 + k));
      chk_flags("full2", 16);
      cyc(1'b1, 1'b1, data_t'(32'h300));
      chk("fullrw.rddata", o_rddata, data_t'(32'h200));
      chk_flags("fullrw", 15);
      for (int k = 1; k < 16; k++) begin
         cyc(1'b0, 1'b1, '0);
         chk($sformatf("fulldrain%0d", k), o_rddata, data_t'(32'h200 + k));
      end
      chk_flags("fulldrain_done", 0);

      // Reset mid-operation with count 8
      for (int k = 0; k < 8; k++) cyc(1'b1, 1'b0, data_t'(32'h400 + k));
      chk_flags("pre_rst", 8);
      rstn = 1'b1;
      cyc(1'b1, 1'b1, data_t'(32'hDEAD));
      rstn = 1'b0;
      chk_flags("midrst", 0);
      chk("midrst.rddata", o_rddata, '0);
      cyc(1'b1, 1'b0, data_t'(32'h500));
      chk_flags("post_rst_wr", 1);
      cyc(1'b0, 1'b1, '0);
      chk("post_rst_rd", o_rddata, data_t'(32'h500));
      chk_flags("post_rst_rd", 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
